// File: rtl/io_pio_arbiter_if.sv
// Write-port bundle between the two requesters and the PIO bank.
// master: requester/bank side; slave: the arbiter.
interface io_pio_arbiter_if;
    logic        req0;
    logic [7:0]  addr0;
    logic [31:0] data0;
    logic        ack0;
    logic        req1;
    logic [7:0]  addr1;
    logic [31:0] data1;
    logic        ack1;
    logic [7:0]  pio_addr;
    logic [31:0] pio_data;
    logic        pio_we;
    logic        busy;

    modport master (
        output req0, addr0, data0, req1, addr1, data1,
        input  ack0, ack1, pio_addr, pio_data, pio_we, busy
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1,
        output ack0, ack1, pio_addr, pio_data, pio_we, busy
    );
endinterface

// File: rtl/io_pio_arbiter.sv
// Two-port write arbiter in front of a PIO output register bank, one holding slot per port.
// Define IO_PIO_ARB_PRIO_EN for fixed port-0 priority; default is round-robin.
module io_pio_arbiter (
    input  logic              clk,
    input  logic              reset,
    io_pio_arbiter_if.slave   bus
);

    logic        full0_q, full0_d, full1_q, full1_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic [7:0]  addr0_q, addr0_d, addr1_q, addr1_d;
    logic [31:0] data0_q, data0_d, data1_q, data1_d;
    logic [7:0]  pio_addr_q, pio_addr_d;
    logic [31:0] pio_data_q, pio_data_d;
    logic        pio_we_q, pio_we_d;
    logic        busy_q, busy_d;
`ifndef IO_PIO_ARB_PRIO_EN
    logic        last_q, last_d;
`endif

    logic        acc0, acc1, elig0, elig1, gnt0, gnt1;
    logic [7:0]  src_addr0, src_addr1;
    logic [31:0] src_data0, src_data1;

    always_comb begin
        acc0  = bus.req0 && !full0_q && !ack0_q;
        acc1  = bus.req1 && !full1_q && !ack1_q;
        // A request accepted this edge competes immediately, giving the E+1 write latency.
        elig0 = full0_q || acc0;
        elig1 = full1_q || acc1;

        src_addr0 = full0_q ? addr0_q : bus.addr0;
        src_data0 = full0_q ? data0_q : bus.data0;
        src_addr1 = full1_q ? addr1_q : bus.addr1;
        src_data1 = full1_q ? data1_q : bus.data1;

`ifdef IO_PIO_ARB_PRIO_EN
        gnt0 = elig0;
        gnt1 = elig1 && !elig0;
`else
        if (elig0 && elig1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
`endif

        ack0_d  = acc0;
        ack1_d  = acc1;
        addr0_d = acc0 ? bus.addr0 : addr0_q;
        data0_d = acc0 ? bus.data0 : data0_q;
        addr1_d = acc1 ? bus.addr1 : addr1_q;
        data1_d = acc1 ? bus.data1 : data1_q;

        // A granted accept bypasses the slot, so it never becomes full.
        full0_d = (full0_q || acc0) && !gnt0;
        full1_d = (full1_q || acc1) && !gnt1;

        pio_we_d   = gnt0 || gnt1;
        pio_addr_d = pio_addr_q;
        pio_data_d = pio_data_q;
        if (gnt0) begin
            pio_addr_d = src_addr0;
            pio_data_d = src_data0;
        end else if (gnt1) begin
            pio_addr_d = src_addr1;
            pio_data_d = src_data1;
        end

        busy_d = full0_d || full1_d || pio_we_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full0_q    <= 1'b0;
            full1_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            addr0_q    <= 8'h00;
            addr1_q    <= 8'h00;
            data0_q    <= 32'h0;
            data1_q    <= 32'h0;
            pio_addr_q <= 8'h00;
            pio_data_q <= 32'h0;
            pio_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            full0_q    <= full0_d;
            full1_q    <= full1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            pio_addr_q <= pio_addr_d;
            pio_data_q <= pio_data_d;
            pio_we_q   <= pio_we_d;
            busy_q     <= busy_d;
        end
    end

`ifndef IO_PIO_ARB_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.pio_addr = pio_addr_q;
    assign bus.pio_data = pio_data_q;
    assign bus.pio_we   = pio_we_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_io_pio_arbiter.sv
// Directed vector bench for io_pio_arbiter; expected values are hand-computed per cycle.
module tb_io_pio_arbiter;

    logic clk;
    logic reset;
    io_pio_arbiter_if bus ();

    io_pio_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        r0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic        e_ack0;
        logic        e_ack1;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(logic rst, logic r0, logic [7:0] a0, logic [31:0] d0,
                                logic r1, logic [7:0] a1, logic [31:0] d1,
                                logic ea0, logic ea1, logic ewe, logic [7:0] eaddr,
                                logic [31:0] edata, logic ebusy);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1; v.d1 = d1;
        v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_we = ewe; v.e_addr = eaddr; v.e_data = edata;
        v.e_busy = ebusy;
        vecs.push_back(v);
    endfunction

    function automatic logic [43:0] outs();
        return {bus.ack0, bus.ack1, bus.pio_we, bus.pio_addr, bus.pio_data, bus.busy};
    endfunction

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ack0/ack1/we/addr/data/busy=%0b/%0b/%0b/%h/%h/%0b want %0b/%0b/%0b/%h/%h/%0b",
                     name, act[43], act[42], act[41], act[40:33], act[32:1], act[0],
                     exp[43], exp[42], exp[41], exp[40:33], exp[32:1], exp[0]);
        end
    endtask

    task automatic drive(input logic rst, input logic r0, input logic [7:0] a0,
                         input logic [31:0] d0, input logic r1, input logic [7:0] a1,
                         input logic [31:0] d1);
        reset = rst; bus.req0 = r0; bus.addr0 = a0; bus.data0 = d0;
        bus.req1 = r1; bus.addr1 = a1; bus.data1 = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic got;
        drive(1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0);

        // Reset with both requests high: outputs stay 0.
        add(1, 1, 8'h04, 32'hA5, 1, 8'h08, 32'h22, 0, 0, 0, 8'h00, 32'h0, 0);
        add(1, 1, 8'h04, 32'hA5, 1, 8'h08, 32'h22, 0, 0, 0, 8'h00, 32'h0, 0);
        // Simultaneous after reset: both acked together, port 0 written first.
        add(0, 1, 8'h00, 32'h11, 1, 8'h08, 32'h22, 1, 1, 1, 8'h00, 32'h11, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 1, 8'h08, 32'h22, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h08, 32'h22, 0);
        // Repeat: last = 1 again, so port 0 first again.
        add(0, 1, 8'h00, 32'h33, 1, 8'h08, 32'h44, 1, 1, 1, 8'h00, 32'h33, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 1, 8'h08, 32'h44, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h08, 32'h44, 0);
        // Single uncontested write.
        add(0, 1, 8'h04, 32'hA5, 0, 8'h00, 32'h0, 1, 0, 1, 8'h04, 32'hA5, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h04, 32'hA5, 0);
        // Tie with last = 0: round-robin picks port 1, priority mode picks port 0.
`ifdef IO_PIO_ARB_PRIO_EN
        add(0, 1, 8'h10, 32'h55, 1, 8'h14, 32'h66, 1, 1, 1, 8'h10, 32'h55, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 1, 8'h14, 32'h66, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h14, 32'h66, 0);
`else
        add(0, 1, 8'h10, 32'h55, 1, 8'h14, 32'h66, 1, 1, 1, 8'h14, 32'h66, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 1, 8'h10, 32'h55, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h10, 32'h55, 0);
`endif
        // req1 held 4 cycles: exactly two captures.
        add(0, 0, 8'h00, 32'h0, 1, 8'h20, 32'h77, 0, 1, 1, 8'h20, 32'h77, 1);
        add(0, 0, 8'h00, 32'h0, 1, 8'h20, 32'h77, 0, 0, 0, 8'h20, 32'h77, 0);
        add(0, 0, 8'h00, 32'h0, 1, 8'h20, 32'h77, 0, 1, 1, 8'h20, 32'h77, 1);
        add(0, 0, 8'h00, 32'h0, 1, 8'h20, 32'h77, 0, 0, 0, 8'h20, 32'h77, 0);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h20, 32'h77, 0);
        // Reset while port 1 write is pending: it is lost.
        add(0, 1, 8'h24, 32'h88, 1, 8'h28, 32'h99, 1, 1, 1, 8'h24, 32'h88, 1);
        add(1, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0, 0);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0, 0);
        // Port 0 re-requests every cycle; port 1 still written the cycle after its ack.
        add(0, 1, 8'h30, 32'hA1, 1, 8'h34, 32'hB2, 1, 1, 1, 8'h30, 32'hA1, 1);
        add(0, 1, 8'h30, 32'hC3, 0, 8'h00, 32'h0, 0, 0, 1, 8'h34, 32'hB2, 1);
        add(0, 1, 8'h30, 32'hC3, 0, 8'h00, 32'h0, 1, 0, 1, 8'h30, 32'hC3, 1);
        add(0, 0, 8'h00, 32'h0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h30, 32'hC3, 0);

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].r0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].a1, vecs[i].d1);
            step();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_ack0, vecs[i].e_ack1, vecs[i].e_we, vecs[i].e_addr,
                   vecs[i].e_data, vecs[i].e_busy});
        end

        // Requester holds req0 until ack0, with a bounded wait.
        drive(1'b0, 1'b1, 8'h3C, 32'hDEADBEEF, 1'b0, 8'h00, 32'h0);
        got = 1'b0;
        for (int n = 0; n < 4 && !got; n++) begin
            step();
            if (bus.ack0) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL hold_ack0: got no ack0 want ack0 within 4 cycles");
        end else begin
            check("hold_write", outs(), {1'b1, 1'b0, 1'b1, 8'h3C, 32'hDEADBEEF, 1'b1});
        end
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0);
        step();
        check("hold_idle", outs(), {1'b0, 1'b0, 1'b0, 8'h3C, 32'hDEADBEEF, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
